sysid_boot_checker: RTL
=======================

Name: sysid_boot_checker

Overview:
- Avalon-MM read sequencer sitting between the system-ID slave and the reset/boot control logic.
- After reset or a start pulse, reads ID word (address 0) and timestamp word (address 1), compares both against build-time expected values, and reports match/mismatch.
- Gates software boot on a hardware/software image-consistency check.
- Handles slave wait-states, a per-read timeout, and a bounded retry count.

Parameters:
EXPECTED_ID, 32'd0, expected value at address 0
EXPECTED_TS, 32'd1465728357, expected value at address 1
TIMEOUT_CYCLES, 255, max cycles a read may stall on waitrequest before it counts as failed (8-bit counter)
MAX_RETRIES, 3, full-sequence retries after a mismatch or timeout before FAIL
PERIOD_CYCLES, 1000000, recheck interval; used only with the optional feature

Ports:
clock  input  1  system clock
reset_n  input  1  asynchronous active-low reset
start  input  1  single-cycle pulse; launches a check from IDLE, DONE or FAIL
avm_address  output  1  slave word address (0 = ID, 1 = timestamp)
avm_read  output  1  read strobe
avm_readdata  input  32  slave read data
avm_waitrequest  input  1  slave stall; read completes in the first cycle with avm_read=1 and waitrequest=0
id_value  output  32  last captured ID word
ts_value  output  32  last captured timestamp word
busy  output  1  sequence in progress
done  output  1  sticky; check finished with match
match  output  1  sticky; both words equal expected values
error  output  1  sticky; retries exhausted
retry_count  output  2  retries consumed in current sequence

Behaviour:
- Reset (async assert, sync release): state=IDLE. All outputs 0, including id_value, ts_value, counters, avm_read and avm_address.
- First clock after reset release: auto-launch, as an implicit start.
- States:
  - IDLE: wait for auto-launch or start.
  - RD_ID: avm_address=0, avm_read=1. On waitrequest=0, capture readdata into id_value and go to RD_TS.
  - RD_TS: avm_address=1, avm_read=1. On waitrequest=0, capture ts_value and go to CHECK.
  - CHECK: one cycle.
    - If id_value==EXPECTED_ID and ts_value==EXPECTED_TS: done=1, match=1, go to DONE.
    - Otherwise go to RETRY.
  - RETRY: one idle cycle with avm_read=0.
    - If retry_count<MAX_RETRIES: increment retry_count and go to RD_ID.
    - Otherwise error=1 and go to FAIL.
  - DONE, FAIL: hold; start relaunches.
- Relaunch from DONE/FAIL: clears done, match, error and retry_count in the same cycle, then enters RD_ID.
- Bus protocol:
  - avm_read and avm_address are registered and stable while waitrequest=1.
  - avm_read deasserts for at least one cycle between RD_TS completion and any new RD_ID.
- Timeout: an 8-bit stall counter resets on entry to each RD_* state and increments every waitrequest=1 cycle. Reaching TIMEOUT_CYCLES drops avm_read, skips the remaining read, and goes to RETRY. id_value and ts_value keep their prior contents.
- Latency, zero wait-state slave, start in cycle 0:
  - RD_ID in cycles 1..1, RD_TS in 2..2, CHECK in 3.
  - done=1 visible from cycle 4.
- busy=1 in RD_ID, RD_TS, CHECK and RETRY.
- start while busy is ignored.
- start and a read completion in the same cycle: the read completion wins.
- reset_n asserted mid-read: avm_read drops immediately and asynchronously, and all sticky flags clear.
- Exactly one of {done, error} is 1 in DONE/FAIL. Both are 0 while busy.

Optional Feature:
SYSID_CHECK_PERIODIC_EN
- Defined: a 32-bit interval counter runs in DONE. On reaching PERIOD_CYCLES-1, the FSM relaunches the sequence.
  - done stays 1 during the recheck until CHECK.
  - A failed recheck sets error=1 and clears done and match.
  - start in DONE also resets the interval counter.
- Undefined: no interval counter is synthesized. DONE holds until start.

Test Plan:
- Zero wait-states, ID=0, TS=1465728357 after reset release -> two reads (addr 0 then 1); done=match=1 at cycle 4; error=0; retry_count=0.
- Slave holds waitrequest=1 for 5 cycles on each read -> avm_read/address stable throughout; done at cycle 14; id_value=0, ts_value=1465728357.
- Slave returns TS=0x12345678 always, MAX_RETRIES=3 -> 4 full sequences, retry_count=3, error=1, done=0, match=0, state FAIL.
- waitrequest stuck high, TIMEOUT_CYCLES=255 -> avm_read drops after 255 stall cycles, retry occurs, error=1 after final retry; ts_value unchanged.
- reset_n pulsed low during RD_TS stall -> avm_read=0 immediately, all flags 0; the check relaunches and passes after release.
- With SYSID_CHECK_PERIODIC_EN, PERIOD_CYCLES=100 -> relaunch 100 cycles after DONE; changing slave TS before the recheck yields error=1, done=0.

Source files
------------

// File: rtl/sysid_boot_checker.sv
// Avalon-MM boot-time system-ID checker: reads ID and timestamp words, compares them to build-time values.
// Optional periodic recheck in DONE is enabled by defining SYSID_CHECK_PERIODIC_EN.
module sysid_boot_checker #(
    parameter logic [31:0] EXPECTED_ID    = 32'd0,
    parameter logic [31:0] EXPECTED_TS    = 32'd1465728357,
    parameter int unsigned TIMEOUT_CYCLES = 255,
    parameter int unsigned MAX_RETRIES    = 3,
    parameter int unsigned PERIOD_CYCLES  = 1000000
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic [31:0] avm_readdata,
    input  logic        avm_waitrequest,
    output logic [31:0] id_value,
    output logic [31:0] ts_value,
    output logic        busy,
    output logic        done,
    output logic        match,
    output logic        error,
    output logic [1:0]  retry_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RD_ID = 3'd1;
    localparam logic [2:0] S_RD_TS = 3'd2;
    localparam logic [2:0] S_CHECK = 3'd3;
    localparam logic [2:0] S_RETRY = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;
    localparam logic [2:0] S_FAIL  = 3'd6;

    // Stall counter value on the TIMEOUT_CYCLES-th waitrequest cycle of a read.
    localparam logic [7:0] STALL_LAST  = 8'(TIMEOUT_CYCLES - 1);
    localparam logic [1:0] RETRY_LIMIT = 2'(MAX_RETRIES);

    logic [2:0] state;
    logic [7:0] stall_cnt;
    logic       auto_go;
    logic       launch;

`ifdef SYSID_CHECK_PERIODIC_EN
    localparam logic [31:0] PERIOD_LAST = 32'(PERIOD_CYCLES - 1);
    logic [31:0] period_cnt;
`endif

    always_comb begin
        launch = 1'b0;
        if (state == S_IDLE)
            launch = auto_go | start;
        else if (state == S_DONE || state == S_FAIL)
            launch = start;
    end

    always_comb begin
        busy = (state == S_RD_ID) || (state == S_RD_TS) ||
               (state == S_CHECK) || (state == S_RETRY);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            auto_go     <= 1'b1;
            stall_cnt   <= '0;
            avm_read    <= 1'b0;
            avm_address <= 1'b0;
            id_value    <= '0;
            ts_value    <= '0;
            done        <= 1'b0;
            match       <= 1'b0;
            error       <= 1'b0;
            retry_count <= '0;
`ifdef SYSID_CHECK_PERIODIC_EN
            period_cnt  <= '0;
`endif
        end else begin
            auto_go <= 1'b0;
            if (launch) begin
                done        <= 1'b0;
                match       <= 1'b0;
                error       <= 1'b0;
                retry_count <= '0;
                stall_cnt   <= '0;
                avm_read    <= 1'b1;
                avm_address <= 1'b0;
                state       <= S_RD_ID;
`ifdef SYSID_CHECK_PERIODIC_EN
                period_cnt  <= '0;
`endif
            end else begin
                case (state)
                    S_RD_ID: begin
                        if (!avm_waitrequest) begin
                            id_value    <= avm_readdata;
                            avm_address <= 1'b1;
                            stall_cnt   <= '0;
                            state       <= S_RD_TS;
                        end else if (stall_cnt == STALL_LAST) begin
                            avm_read <= 1'b0;
                            state    <= S_RETRY;
                        end else begin
                            stall_cnt <= stall_cnt + 8'd1;
                        end
                    end
                    S_RD_TS: begin
                        if (!avm_waitrequest) begin
                            ts_value <= avm_readdata;
                            avm_read <= 1'b0;
                            state    <= S_CHECK;
                        end else if (stall_cnt == STALL_LAST) begin
                            avm_read <= 1'b0;
                            state    <= S_RETRY;
                        end else begin
                            stall_cnt <= stall_cnt + 8'd1;
                        end
                    end
                    S_CHECK: begin
                        if (id_value == EXPECTED_ID && ts_value == EXPECTED_TS) begin
                            done  <= 1'b1;
                            match <= 1'b1;
                            state <= S_DONE;
`ifdef SYSID_CHECK_PERIODIC_EN
                            period_cnt <= '0;
`endif
                        end else begin
                            // A failing periodic recheck withdraws the earlier pass here.
                            done  <= 1'b0;
                            match <= 1'b0;
                            state <= S_RETRY;
                        end
                    end
                    S_RETRY: begin
                        if (retry_count < RETRY_LIMIT) begin
                            retry_count <= retry_count + 2'd1;
                            stall_cnt   <= '0;
                            avm_read    <= 1'b1;
                            avm_address <= 1'b0;
                            state       <= S_RD_ID;
                        end else begin
                            error <= 1'b1;
                            state <= S_FAIL;
                        end
                    end
                    S_DONE: begin
`ifdef SYSID_CHECK_PERIODIC_EN
                        if (period_cnt == PERIOD_LAST) begin
                            period_cnt  <= '0;
                            retry_count <= '0;
                            stall_cnt   <= '0;
                            avm_read    <= 1'b1;
                            avm_address <= 1'b0;
                            state       <= S_RD_ID;
                        end else begin
                            period_cnt <= period_cnt + 32'd1;
                        end
`endif
                    end
                    S_IDLE, S_FAIL: begin
                    end
                    default: state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
